// File: rtl/y86_mem_arbiter.sv
// rtl/y86_mem_arbiter.sv - two-port (CPU/DMA) arbiter for the single y86 memory bus
// One transfer at a time: IDLE latches a winner, ACCESS drives the bus, RESP pulses done.
module y86_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_WAIT   = 15,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_A,
    output logic          mem_RE,
    output logic          mem_WE,
    output logic [DW-1:0] mem_out,
    input  logic [DW-1:0] mem_in,
    input  logic          mem_ready,
    output logic          bus_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 0 = CPU, 1 = DMA
    logic          last_q, last_d;        // owner of the last completed transfer
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          grant_dma;

    // DMA wins only when alone, or on a round-robin tie after a CPU transfer
    assign grant_dma = dma_req && (!cpu_req || (FIXED_PRIO == 0 && !last_q));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d = grant_dma;
                    we_d    = grant_dma ? dma_we    : cpu_we;
                    addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready) begin
                    if (!we_q) begin
                        if (owner_q) dma_rdata_d = mem_in;
                        else         cpu_rdata_d = mem_in;
                    end
                    last_d  = owner_q;
                    state_d = S_RESP;
                end else if (cnt_q + 8'd1 == MAX_WAIT_C) begin
                    if (owner_q) dma_rdata_d = '0;
                    else         cpu_rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Bus outputs decode straight from state so an async reset drops them at once
    always_comb begin
        cpu_gnt   = (state_q == S_ACCESS) && !owner_q;
        dma_gnt   = (state_q == S_ACCESS) &&  owner_q;
        cpu_done  = (state_q == S_RESP)   && !owner_q;
        dma_done  = (state_q == S_RESP)   &&  owner_q;
        bus_err   = (state_q == S_RESP)   &&  err_q;
        mem_RE    = (state_q == S_ACCESS) && !we_q;
        mem_WE    = (state_q == S_ACCESS) &&  we_q;
        mem_A     = (state_q == S_ACCESS) ? addr_q  : '0;
        mem_out   = (state_q == S_ACCESS) ? wdata_q : '0;
        cpu_rdata = cpu_rdata_q;
        dma_rdata = dma_rdata_q;
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb/tb_y86_mem_arbiter.sv - directed checks of y86_mem_arbiter
// Two instances share inputs: round-robin (u_rr) and fixed-priority (u_fp).
module tb_y86_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_in;

    logic        cpu_gnt, cpu_done, dma_gnt, dma_done, mem_RE, mem_WE, bus_err;
    logic [31:0] cpu_rdata, dma_rdata, mem_A, mem_out;

    logic        fp_cpu_gnt, fp_cpu_done, fp_dma_gnt, fp_dma_done, fp_mem_RE, fp_mem_WE, fp_bus_err;
    logic [31:0] fp_cpu_rdata, fp_dma_rdata, fp_mem_A, fp_mem_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    y86_mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(15), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_A(mem_A), .mem_RE(mem_RE), .mem_WE(mem_WE), .mem_out(mem_out),
        .mem_in(mem_in), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    y86_mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(15), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(fp_cpu_gnt), .cpu_done(fp_cpu_done), .cpu_rdata(fp_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(fp_dma_gnt), .dma_done(fp_dma_done), .dma_rdata(fp_dma_rdata),
        .mem_A(fp_mem_A), .mem_RE(fp_mem_RE), .mem_WE(fp_mem_WE), .mem_out(fp_mem_out),
        .mem_in(mem_in), .mem_ready(mem_ready), .bus_err(fp_bus_err)
    );

    typedef struct {
        int          port;       // 0 = CPU, 1 = DMA
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rin;
        int          wait_n;     // ACCESS cycles without ready before ready
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_access;
    } vec_t;

    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic xfer(input vec_t v);
        int n_acc;
        @(negedge clk);
        if (v.port == 0) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end
        @(posedge clk);
        @(negedge clk);
        n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            if ((v.port == 0) ? cpu_done : dma_done) break;
            chk1("own_gnt",   (v.port == 0) ? cpu_gnt : dma_gnt, 1'b1);
            chk1("other_gnt", (v.port == 0) ? dma_gnt : cpu_gnt, 1'b0);
            chk32("mem_A", mem_A, v.addr);
            chk1("mem_WE", mem_WE, v.we);
            chk1("mem_RE", mem_RE, !v.we);
            if (v.we) chk32("mem_out", mem_out, v.wdata);
            n_acc++;
            mem_ready = (n_acc == v.wait_n + 1);
            mem_in    = v.rin;
            @(posedge clk);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_in    = 32'h0;
        chk32("access_cycles", n_acc, v.exp_access);
        chk1("own_done",   (v.port == 0) ? cpu_done : dma_done, 1'b1);
        chk1("other_done", (v.port == 0) ? dma_done : cpu_done, 1'b0);
        chk32("rdata", (v.port == 0) ? cpu_rdata : dma_rdata, v.exp_rdata);
        chk1("bus_err", bus_err, v.exp_err);
        chk1("resp_gnt", cpu_gnt | dma_gnt, 1'b0);
        chk1("resp_strobe", mem_RE | mem_WE, 1'b0);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1("done_one_cycle", cpu_done | dma_done | bus_err, 1'b0);
    endtask

    initial begin
        int rr_seq[$];
        int fp_seq[$];

        vecs[0] = '{0, 1'b0, 32'h10, 32'h0,    32'hDEADBEEF, 0,   32'hDEADBEEF, 1'b0, 1};
        vecs[1] = '{1, 1'b1, 32'h40, 32'h1234, 32'h0,        3,   32'h0,        1'b0, 4};
        vecs[2] = '{1, 1'b0, 32'h44, 32'h0,    32'hCAFEF00D, 1,   32'hCAFEF00D, 1'b0, 2};
        vecs[3] = '{1, 1'b1, 32'h48, 32'h9999, 32'h11111111, 0,   32'hCAFEF00D, 1'b0, 1};
        vecs[4] = '{0, 1'b1, 32'h20, 32'hA5A5, 32'h22222222, 2,   32'hDEADBEEF, 1'b0, 3};
        vecs[5] = '{0, 1'b0, 32'h24, 32'h0,    32'h33333333, 100, 32'h0,        1'b1, 15};
        vecs[6] = '{0, 1'b0, 32'h30, 32'h0,    32'h000055AA, 0,   32'h000055AA, 1'b0, 1};
        vecs[7] = '{1, 1'b0, 32'h4C, 32'h0,    32'h44444444, 100, 32'h0,        1'b1, 15};

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        mem_ready = 1'b0; mem_in = 32'h0;
        repeat (2) @(negedge clk);
        chk1("rst_gnt", cpu_gnt | dma_gnt, 1'b0);
        chk1("rst_done", cpu_done | dma_done, 1'b0);
        chk1("rst_strobe", mem_RE | mem_WE, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk32("rst_dma_rdata", dma_rdata, 32'h0);
        chk32("rst_mem_A", mem_A, 32'h0);
        chk32("rst_mem_out", mem_out, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) xfer(vecs[i]);

        // Reset in the middle of an access
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
        @(posedge clk);
        @(negedge clk);
        chk1("pre_rst_gnt", cpu_gnt, 1'b1);
        chk1("pre_rst_RE", mem_RE, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst_gnt", cpu_gnt, 1'b0);
        chk1("async_rst_RE", mem_RE, 1'b0);
        chk32("async_rst_mem_A", mem_A, 32'h0);

        // Both request continuously with immediate ready
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h54;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h60;
        mem_ready = 1'b1; mem_in = 32'h77;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (cpu_gnt)    rr_seq.push_back(0);
            if (dma_gnt)    rr_seq.push_back(1);
            if (fp_cpu_gnt) fp_seq.push_back(0);
            if (fp_dma_gnt) fp_seq.push_back(1);
            chk1("gnt_exclusive", cpu_gnt & dma_gnt, 1'b0);
            chk1("done_exclusive", cpu_done & dma_done, 1'b0);
            chk1("strobe_exclusive", mem_RE & mem_WE, 1'b0);
        end
        cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
        chk32("rr_grant_count", rr_seq.size(), 4);
        chk32("fp_grant_count", fp_seq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk32("rr_order", (i < rr_seq.size()) ? rr_seq[i] : -1, i % 2);
            chk32("fp_order", (i < fp_seq.size()) ? fp_seq[i] : -1, 0);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
